// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  imem_loader_if : byte-stream input and instruction-memory write bus
//  Rev 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // master: the loader (consumes bytes, drives the memory write port)
    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    // slave: host stream source plus instruction memory
    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  imem_loader : packs a host byte stream into LE 32-bit words and writes
//  them to instruction memory from word 0. Option: IMEM_LOADER_CHECKSUM_EN.
//  Rev 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    imem_loader_if.master   bus,
    output logic            core_hold,
    output logic            busy,
    output logic            done,
    output logic            len_err,
    output logic            csum_err
);

    localparam logic [ADDR_W:0] c_max_words = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM    = 3'd4,
`endif
        S_DONE    = 3'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [23:0]       r_word;

    logic              w_len_err;
    logic [ADDR_W-1:0] w_last;
    logic [31:0]       w_full_word;
    logic              w_byte_acc;

    assign w_len_err   = (word_count > c_max_words);
    // Clamped count minus one; a count of exactly 2^ADDR_W wraps to all-ones as intended.
    assign w_last      = w_len_err ? '1 : (word_count[ADDR_W-1:0] - ADDR_W'(1));
    assign w_full_word = {bus.byte_in, r_word};
    assign w_byte_acc  = bus.byte_valid && bus.byte_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_csum_err;
    assign csum_err = r_csum_err;
`else
    assign csum_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_lane         <= 2'd0;
            r_idx          <= '0;
            r_last         <= '0;
            r_word         <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            core_hold      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            len_err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
            r_csum_err     <= 1'b0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_err <= w_len_err;
                        r_idx   <= '0;
                        r_lane  <= 2'd0;
                        r_last  <= w_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum      <= '0;
                        r_csum_err <= 1'b0;
`endif
                        if (word_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state        <= S_CSUM;
                            bus.byte_ready <= 1'b1;
                            busy           <= 1'b1;
                            core_hold      <= 1'b1;
                            done           <= 1'b0;
`else
                            r_state        <= S_DONE;
                            bus.byte_ready <= 1'b0;
                            busy           <= 1'b0;
                            core_hold      <= 1'b0;
                            done           <= 1'b1;
`endif
                        end else begin
                            r_state        <= S_COLLECT;
                            bus.byte_ready <= 1'b1;
                            busy           <= 1'b1;
                            core_hold      <= 1'b1;
                            done           <= 1'b0;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_byte_acc) begin
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            // The 4th byte goes straight onto the bus; it never lands in r_word.
                            r_state        <= S_WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.mem_we     <= 1'b1;
                            bus.mem_addr   <= r_idx;
                            bus.mem_wdata  <= w_full_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_sum          <= r_sum + w_full_word;
`endif
                        end else begin
                            r_word[r_lane*8 +: 8] <= bus.byte_in;
                        end
                    end
                end

                S_WRITE: begin
                    r_lane <= 2'd0;
                    if (r_idx == r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state        <= S_CSUM;
                        bus.byte_ready <= 1'b1;
`else
                        r_state        <= S_DONE;
                        busy           <= 1'b0;
                        core_hold      <= 1'b0;
                        done           <= 1'b1;
`endif
                    end else begin
                        r_state        <= S_COLLECT;
                        r_idx          <= r_idx + ADDR_W'(1);
                        bus.byte_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_byte_acc) begin
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_state        <= S_DONE;
                            bus.byte_ready <= 1'b0;
                            busy           <= 1'b0;
                            core_hold      <= 1'b0;
                            done           <= 1'b1;
                            r_csum_err     <= (r_sum != w_full_word);
                        end else begin
                            r_word[r_lane*8 +: 8] <= bus.byte_in;
                        end
                    end
                end
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  tb_imem_loader : randomized self-checking bench against a word-level model
//  Rev 1.0
// ============================================================================
module tb_imem_loader;

    // Narrow address space so the overlength/clamp case fits a short run.
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          core_hold, busy, done, len_err, csum_err;

    imem_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .csum_err   (csum_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_a[$];
    logic [31:0] wr_d[$];
    int          lat_bad, rdy_bad, acc_cnt, rdy_cycles;
    bit          prev_acc;
    logic [31:0] ref_words[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_a.delete();
        wr_d.delete();
        lat_bad    = 0;
        rdy_bad    = 0;
        acc_cnt    = 0;
        rdy_cycles = 0;
    endtask

    // Memory side: capture writes and handshake observations mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_a.push_back(int'(bus.mem_addr));
            wr_d.push_back(bus.mem_wdata);
            if (bus.byte_ready) rdy_bad++;
            if (!prev_acc) lat_bad++;
        end
        if (bus.byte_ready) rdy_cycles++;
        prev_acc = bus.byte_valid && bus.byte_ready;
        if (prev_acc) acc_cnt++;
    end

    task automatic do_load(input int cnt, input int mode, input bit mid_start, input bit bad_csum);
        int          exp_n, pos, guard, mism;
        bit          exp_len, acc, v, vtog, fired;
        logic [31:0] sum, w, cs;
        logic [7:0]  bytes[$];

        exp_n   = (cnt > DEPTH) ? DEPTH : cnt;
        exp_len = (cnt > DEPTH);
        while (ref_words.size() < exp_n) ref_words.push_back($urandom);
        sum = 32'd0;
        for (int i = 0; i < exp_n; i++) begin
            w   = ref_words[i];
            sum = sum + w;
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs = bad_csum ? sum + 32'd1 : sum;
        for (int b = 0; b < 4; b++) bytes.push_back(cs[8*b +: 8]);
`else
        cs = sum;
`endif

        clear_mon();
        word_count = cnt[AW:0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (cnt == 0) check("zero_done_next", done, 1);
`endif

        pos = 0; guard = 0; vtog = 1'b1; fired = 1'b0;
        while (pos < bytes.size() && guard < 20 * bytes.size() + 20) begin
            bus.byte_in = bytes[pos];
            case (mode)
                0:       v = 1'b1;
                1:       begin v = vtog; vtog = !vtog; end
                default: v = ($urandom_range(99) < 60);
            endcase
            bus.byte_valid = v;
            if (mid_start && pos == 2 && !fired) begin
                start      = 1'b1;
                word_count = '0;
                fired      = 1'b1;
            end
            acc = v && bus.byte_ready;
            tick();
            start      = 1'b0;
            word_count = cnt[AW:0];
            if (acc) pos++;
            guard++;
        end
        bus.byte_valid = 1'b0;
        for (int k = 0; k < 10 && !done; k++) tick();
        repeat (2) tick();

        check("bytes_fed", pos, bytes.size());
        check("done", done, 1);
        check("busy", busy, 0);
        check("core_hold", core_hold, 0);
        check("len_err", len_err, exp_len);
        check("csum_err", csum_err, bad_csum && (cs != sum));
        check("n_writes", wr_a.size(), exp_n);
        mism = 0;
        for (int i = 0; i < wr_a.size() && i < exp_n; i++)
            if (wr_a[i] != i || wr_d[i] !== ref_words[i]) mism++;
        check("wr_mism", mism, 0);
        if (exp_n > 0 && wr_a.size() > 0) check("last_addr", wr_a[$], exp_n - 1);
        if (exp_n <= 2)
            for (int i = 0; i < wr_a.size() && i < exp_n; i++)
                check("wr_data", wr_d[i], ref_words[i]);
        check("we_latency", lat_bad, 0);
        check("rdy_in_write", rdy_bad, 0);
        check("acc_cnt", acc_cnt, bytes.size());
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (cnt == 0) check("zero_rdy", rdy_cycles, 0);
`endif
        ref_words.delete();
    endtask

    task automatic reset_mid_load();
        logic [7:0]  bytes[$];
        logic [31:0] w;
        int          pos, guard;
        bit          acc;
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            ref_words.push_back(w);
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
        end
        clear_mon();
        word_count = 11'd5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        bus.byte_valid = 1'b1;
        pos = 0; guard = 0;
        while (wr_a.size() < 2 && guard < 100 && pos < bytes.size()) begin
            bus.byte_in = bytes[pos];
            acc = bus.byte_ready;
            tick();
            if (acc) pos++;
            guard++;
        end
        rst_n = 1'b0;
        tick();
        check("rst_core_hold", core_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", bus.byte_ready, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        bus.byte_valid = 1'b0;
        check("rst_writes", wr_a.size(), 2);
        if (wr_d.size() >= 2) begin
            check("rst_w0", wr_d[0], ref_words[0]);
            check("rst_w1", wr_d[1], ref_words[1]);
        end
        check("rst_idle_hold", core_hold, 1);
        ref_words.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        rst_n          = 1'b0;
        repeat (3) tick();
        check("reset_core_hold", core_hold, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_len_err", len_err, 0);
        check("reset_ready", bus.byte_ready, 0);
        check("reset_we", bus.mem_we, 0);
        check("reset_csum_err", csum_err, 0);
        rst_n = 1'b1;
        tick();

        ref_words = '{32'h0000_0013, 32'h0010_0093};
        do_load(2, 0, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ref_words = '{32'h0000_0013, 32'h0010_0093};
        do_load(2, 0, 1'b0, 1'b1);
`endif
        do_load(0, 0, 1'b0, 1'b0);
        do_load(1, 1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++)
            do_load($urandom_range(9, 2), 2, 1'b0, 1'($urandom_range(1)));
        do_load(3, 2, 1'b1, 1'b0);
        reset_mid_load();
        do_load(DEPTH + 1, 0, 1'b0, 1'b0);
        do_load(1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
